pmod_link_rx: RTL and testbench



---
 rtl/pmod_link_rx_if.sv | 32 +++
 rtl/pmod_link_rx.sv | 143 ++++++++++++++
 tb/tb_pmod_link_rx.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/pmod_link_rx_if.sv
// pmod_link_rx_if: pin and result bundle for the Pmod link receiver.
//   *_up_in   : partner person code per bank (4 bits)
//   *_down_in : partner control bundle per bank
//               [0] reset request, [2:1] result, [3] ready, [4] presence
//   link_side : 00 none, 01 right, 10 left
//   partner_* : filtered fields of the locked bank, partner_rst is a pulse
//   link_lost : pulse when a locked link drops
// slave is the receiver side; master is the driver/observer side.
interface pmod_link_rx_if;
  logic [3:0] right_up_in;
  logic [4:0] right_down_in;
  logic [3:0] left_up_in;
  logic [4:0] left_down_in;
  logic [1:0] link_side;
  logic [3:0] partner_person;
  logic       partner_ready;
  logic [1:0] partner_result;
  logic       partner_rst;
  logic       link_lost;

  modport slave (
    input  right_up_in, right_down_in, left_up_in, left_down_in,
    output link_side, partner_person, partner_ready, partner_result,
           partner_rst, link_lost
  );

  modport master (
    output right_up_in, right_down_in, left_up_in, left_down_in,
    input  link_side, partner_person, partner_ready, partner_result,
           partner_rst, link_lost
  );
endinterface

// File: rtl/pmod_link_rx.sv
// pmod_link_rx: receive front end of the two-board link. Synchronises both
// Pmod banks, glitch-filters each 9-bit bundle, locks onto the bank where a
// partner is present and presents one registered set of partner signals.
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : pmod_link_rx_if.slave (raw bank pins in, partner outputs out)
module pmod_link_rx #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1000
) (
  input  logic           clk,
  input  logic           rst,
  pmod_link_rx_if.slave  bus
);
  localparam int            CW      = $clog2(STABLE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  // Word layout {down[4:0], up[3:0]}
  localparam int B_RST  = 4;
  localparam int B_RDY  = 7;
  localparam int B_PRES = 8;

  typedef enum logic [1:0] {
    SEARCH = 2'b00,
    LOCK_R = 2'b01,
    LOCK_L = 2'b10
  } state_t;

  // Bank 0 = right, bank 1 = left
  logic [1:0][8:0]                  raw;
  logic [1:0][SYNC_STAGES-1:0][8:0] sync_q;
  logic [1:0][8:0]                  cand_q, filt_q;
  logic [1:0][CW-1:0]               cnt_q;

  assign raw[0] = {bus.right_down_in, bus.right_up_in};
  assign raw[1] = {bus.left_down_in,  bus.left_up_in};

  // Synchroniser chains: index 0 takes the pin, index SYNC_STAGES-1 is safe
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      for (int b = 0; b < 2; b++)
        sync_q[b] <= {sync_q[b][SYNC_STAGES-2:0], raw[b]};
    end
  end

  // Glitch filter: a new value must be seen STABLE_CYCLES+1 consecutive
  // times (one load plus STABLE_CYCLES-1 counts plus the commit) before it
  // reaches filt_q. The counter saturates instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      cand_q <= '0;
      cnt_q  <= '0;
      filt_q <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (sync_q[b][SYNC_STAGES-1] != cand_q[b]) begin
          cand_q[b] <= sync_q[b][SYNC_STAGES-1];
          cnt_q[b]  <= '0;
        end else if (cnt_q[b] == CNT_MAX) begin
          filt_q[b] <= cand_q[b];
        end else begin
          cnt_q[b]  <= cnt_q[b] + 1'b1;
        end
      end
    end
  end

  state_t     state_q, state_d;
  logic       rst_prev_q, rst_prev_d;
  logic [1:0] side_q, side_d;
  logic [3:0] person_q, person_d;
  logic       ready_q, ready_d;
  logic [1:0] result_q, result_d;
  logic       prst_q, prst_d;
  logic       lost_q, lost_d;
  logic [8:0] cur_w, nxt_w;

  always_comb begin
    state_d = state_q;
    case (state_q)
      SEARCH: begin
        if (filt_q[0][B_PRES])      state_d = LOCK_R;
        else if (filt_q[1][B_PRES]) state_d = LOCK_L;
      end
      LOCK_R:  if (!filt_q[0][B_PRES]) state_d = SEARCH;
      LOCK_L:  if (!filt_q[1][B_PRES]) state_d = SEARCH;
      default: state_d = SEARCH;
    endcase

    // Reset-request edge is judged on the bank locked this cycle, so a rise
    // landing in the same update as a presence drop still pulses.
    cur_w  = (state_q == LOCK_L) ? filt_q[1] : filt_q[0];
    prst_d = (state_q != SEARCH) && cur_w[B_RST] && !rst_prev_q;

    // Outputs follow the next state so lock and valid data appear together.
    // The edge register is primed with the newly locked bank's bit, which
    // suppresses a pulse for a request already high at lock time.
    nxt_w      = (state_d == LOCK_L) ? filt_q[1] : filt_q[0];
    side_d     = state_d;
    person_d   = '0;
    ready_d    = 1'b0;
    result_d   = '0;
    rst_prev_d = 1'b0;
    if (state_d != SEARCH) begin
      person_d   = nxt_w[3:0];
      ready_d    = nxt_w[B_RDY];
      result_d   = nxt_w[6:5];
      rst_prev_d = nxt_w[B_RST];
    end
    lost_d = (state_q != SEARCH) && (state_d == SEARCH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= SEARCH;
      rst_prev_q <= 1'b0;
      side_q     <= '0;
      person_q   <= '0;
      ready_q    <= 1'b0;
      result_q   <= '0;
      prst_q     <= 1'b0;
      lost_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rst_prev_q <= rst_prev_d;
      side_q     <= side_d;
      person_q   <= person_d;
      ready_q    <= ready_d;
      result_q   <= result_d;
      prst_q     <= prst_d;
      lost_q     <= lost_d;
    end
  end

  assign bus.link_side      = side_q;
  assign bus.partner_person = person_q;
  assign bus.partner_ready  = ready_q;
  assign bus.partner_result = result_q;
  assign bus.partner_rst    = prst_q;
  assign bus.link_lost      = lost_q;
endmodule

// File: tb/tb_pmod_link_rx.sv
// tb_pmod_link_rx: bench for pmod_link_rx with SYNC_STAGES=2, STABLE_CYCLES=4.
// A reference model built on pin history windows predicts every output on
// every cycle; directed sequences and a vector table cover the corner cases.
module tb_pmod_link_rx;
  localparam int SY = 2;
  localparam int ST = 4;
  localparam int HL = SY + ST + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pmod_link_rx_if bus_if();

  pmod_link_rx #(.SYNC_STAGES(SY), .STABLE_CYCLES(ST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int npass = 0;
  int ntot  = 0;

  // Model: hist[b][i] is the pin word sampled i edges ago. A bank's filtered
  // value takes hist[b][SY] once the ST+1 samples hist[b][SY..SY+ST] agree.
  logic [8:0] hist [2][HL];
  logic [8:0] fm [2];
  logic [8:0] fm_prev [2];
  int         mside;
  logic [1:0] e_side;
  logic [3:0] e_person;
  logic       e_ready;
  logic [1:0] e_result;
  logic       e_prst, e_lost;

  typedef struct {
    logic [4:0] rd; logic [3:0] ru; logic [4:0] ld; logic [3:0] lu;
    logic [1:0] side; logic [3:0] person; logic ready; logic [1:0] result;
  } vec_t;
  vec_t vt [7];

  task automatic chk(input string nm, input int act, input int exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [8:0] pin_word(input int b);
    return (b == 0) ? {bus_if.right_down_in, bus_if.right_up_in}
                    : {bus_if.left_down_in,  bus_if.left_up_in};
  endfunction

  function automatic logic [10:0] outs();
    return {bus_if.link_side, bus_if.partner_person, bus_if.partner_ready,
            bus_if.partner_result, bus_if.partner_rst, bus_if.link_lost};
  endfunction

  task automatic model_edge();
    logic [8:0] fnew [2];
    logic [8:0] w;
    int         nside;
    bit         same;
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < HL; i++) hist[b][i] = '0;
        fm[b] = '0; fm_prev[b] = '0;
      end
      mside = 0;
      e_side = '0; e_person = '0; e_ready = 1'b0; e_result = '0;
      e_prst = 1'b0; e_lost = 1'b0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        for (int i = HL - 1; i > 0; i--) hist[b][i] = hist[b][i-1];
        hist[b][0] = pin_word(b);
        same = 1'b1;
        for (int i = SY; i <= SY + ST; i++)
          if (hist[b][i] != hist[b][SY]) same = 1'b0;
        fnew[b] = same ? hist[b][SY] : fm[b];
      end
      // Side decision and outputs use the filtered words from the last edge
      nside = mside;
      if (mside == 0) nside = fm[0][8] ? 1 : (fm[1][8] ? 2 : 0);
      else if (!fm[mside-1][8]) nside = 0;
      e_lost = (mside != 0) && (nside == 0);
      e_prst = (mside != 0) && fm[mside-1][4] && !fm_prev[mside-1][4];
      e_side = 2'(nside);
      if (nside != 0) begin
        w = fm[nside-1];
        e_person = w[3:0]; e_ready = w[7]; e_result = w[6:5];
      end else begin
        e_person = '0; e_ready = 1'b0; e_result = '0;
      end
      fm_prev = fm;
      fm      = fnew;
      mside   = nside;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("model", int'(outs()),
        int'({e_side, e_person, e_ready, e_result, e_prst, e_lost}));
  endtask

  task automatic drv(input logic [4:0] rd, input logic [3:0] ru,
                     input logic [4:0] ld, input logic [3:0] lu);
    bus_if.right_down_in = rd; bus_if.right_up_in = ru;
    bus_if.left_down_in  = ld; bus_if.left_up_in  = lu;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int pbad, nlost, lpos, lside, aside, np, ppos;
    logic [4:0] rrd, rld;

    vt[0] = '{5'b00000, 4'h0, 5'b00000, 4'h0, 2'd0, 4'h0, 1'b0, 2'd0};
    vt[1] = '{5'b11000, 4'h7, 5'b00000, 4'h0, 2'd1, 4'h7, 1'b1, 2'd0};
    vt[2] = '{5'b11110, 4'hA, 5'b00000, 4'h0, 2'd1, 4'hA, 1'b1, 2'd3};
    vt[3] = '{5'b11110, 4'hA, 5'b10000, 4'h5, 2'd1, 4'hA, 1'b1, 2'd3};
    vt[4] = '{5'b00000, 4'h0, 5'b10000, 4'h5, 2'd2, 4'h5, 1'b0, 2'd0};
    vt[5] = '{5'b00000, 4'h0, 5'b10010, 4'hC, 2'd2, 4'hC, 1'b0, 2'd1};
    vt[6] = '{5'b00000, 4'h0, 5'b01110, 4'hF, 2'd0, 4'h0, 1'b0, 2'd0};

    drv(0, 0, 0, 0);
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk("reset_state", int'(outs()), 0);
    repeat (12) tick();
    chk("idle", int'(outs()), 0);

    // Right lock: visible exactly 8 edges after the pin change
    drv(5'b11000, 4'h7, 0, 0);
    repeat (7) tick();
    chk("lock_r_early_side", int'(bus_if.link_side), 0);
    tick();
    chk("lock_r_side", int'(bus_if.link_side), 1);
    chk("lock_r_person", int'(bus_if.partner_person), 7);
    chk("lock_r_ready", int'(bus_if.partner_ready), 1);
    chk("lock_r_result", int'(bus_if.partner_result), 0);

    // 3-cycle glitch is swallowed; a held change lands after 8 edges
    pbad = 0;
    drv(5'b11000, 4'h3, 0, 0);
    repeat (3) begin tick(); if (bus_if.partner_person != 4'h7) pbad++; end
    drv(5'b11000, 4'h7, 0, 0);
    repeat (12) begin tick(); if (bus_if.partner_person != 4'h7) pbad++; end
    chk("glitch_hold_bad_cycles", pbad, 0);
    drv(5'b11000, 4'h3, 0, 0);
    repeat (7) tick();
    chk("filter_early_person", int'(bus_if.partner_person), 7);
    tick();
    chk("filter_late_person", int'(bus_if.partner_person), 3);

    for (int i = 0; i < 7; i++) begin
      drv(vt[i].rd, vt[i].ru, vt[i].ld, vt[i].lu);
      repeat (12) tick();
      chk($sformatf("vec%0d_side", i), int'(bus_if.link_side), int'(vt[i].side));
      chk($sformatf("vec%0d_person", i), int'(bus_if.partner_person), int'(vt[i].person));
      chk($sformatf("vec%0d_ready", i), int'(bus_if.partner_ready), int'(vt[i].ready));
      chk($sformatf("vec%0d_result", i), int'(bus_if.partner_result), int'(vt[i].result));
    end

    // Simultaneous presence: right wins; dropping right passes through SEARCH
    drv(5'b10000, 4'h1, 5'b10000, 4'h2);
    repeat (10) tick();
    chk("prio_side", int'(bus_if.link_side), 1);
    drv(5'b00000, 4'h0, 5'b10000, 4'h2);
    nlost = 0; lpos = -10; lside = -1; aside = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == lpos + 1) aside = int'(bus_if.link_side);
      if (bus_if.link_lost) begin
        nlost++; lpos = i; lside = int'(bus_if.link_side);
      end
    end
    chk("drop_lost_count", nlost, 1);
    chk("drop_lost_pos", lpos, 8);
    chk("drop_side_on_lost", lside, 0);
    chk("drop_side_after", aside, 2);

    // Partner reset held high in LOCK_L: one pulse, 8 edges after the rise
    drv(5'b00000, 4'h0, 5'b10001, 4'h2);
    np = 0; ppos = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus_if.partner_rst) begin np++; ppos = i; end
    end
    chk("prst_count", np, 1);
    chk("prst_pos", ppos, 8);
    drv(5'b00000, 4'h0, 5'b10000, 4'h2);
    np = 0;
    repeat (12) begin tick(); if (bus_if.partner_rst) np++; end
    chk("prst_release_count", np, 0);
    drv(5'b00000, 4'h0, 5'b10001, 4'h2);
    repeat (12) begin tick(); if (bus_if.partner_rst) np++; end
    chk("prst_second_count", np, 1);

    // Reset while locked and mid-filter: outputs clear, relock takes 8 edges
    drv(5'b00000, 4'h0, 5'b10000, 4'h9);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    chk("midrst_outputs", int'(outs()), 0);
    rst = 1'b0;
    repeat (7) tick();
    chk("relock_early_side", int'(bus_if.link_side), 0);
    tick();
    chk("relock_side", int'(bus_if.link_side), 2);
    chk("relock_person", int'(bus_if.partner_person), 9);

    // Random segments of varying length, occasional reset
    for (int s = 0; s < 120; s++) begin
      rrd = {($urandom_range(0, 3) != 0), 4'($urandom)};
      rld = {($urandom_range(0, 3) != 0), 4'($urandom)};
      drv(rrd, 4'($urandom), rld, 4'($urandom));
      rst = ($urandom_range(0, 40) == 0);
      tick();
      rst = 1'b0;
      repeat ($urandom_range(0, 9)) tick();
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
